// File: rtl/core_debug_responder_pkg.sv
// Encodings shared by the debugger and the core debug responder:
// command opcodes, response status codes, responder states and result-register sources.
package core_debug_responder_pkg;

    typedef enum logic [3:0] {
        OP_NOP       = 4'h0,
        OP_HALT      = 4'h1,
        OP_RESUME    = 4'h2,
        OP_RESET     = 4'h3,
        OP_READ_REG  = 4'h4,
        OP_WRITE_REG = 4'h5,
        OP_READ_MEM  = 4'h6,
        OP_WRITE_MEM = 4'h7
    } opcode_e;

    typedef enum logic [1:0] {
        STAT_OK         = 2'b00,
        STAT_ILLEGAL    = 2'b01,
        STAT_NOT_HALTED = 2'b10,
        STAT_TIMEOUT    = 2'b11
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_DATA,
        S_GET_ADDR,
        S_EXEC,
        S_WAIT_HALT,
        S_RESET_PULSE,
        S_MEM_WAIT,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        RES_HOLD,
        RES_ZERO,
        RES_REG,
        RES_MEM
    } result_sel_e;

endpackage

// File: rtl/core_debug_responder_ctrl.sv
// Debug responder control: command sequencing FSM, halt flag, status register and
// the shared cycle counter used for the core reset pulse and the memory timeout.
module core_debug_responder_ctrl
    import core_debug_responder_pkg::*;
#(
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        resp_ack,
    input  logic [3:0]  opcode,
    input  logic        core_busy,
    input  logic        mem_ready,
    output logic        cmd_ready,
    output logic        cap_cmd,
    output logic        cap_data,
    output logic        cap_addr,
    output result_sel_e result_sel,
    output logic        resp_valid,
    output logic [1:0]  resp_status,
    output logic        core_halt,
    output logic        core_reset,
    output logic        reg_we,
    output logic        mem_req,
    output logic        mem_we
);

    localparam int unsigned CNT_MAX = (MEM_TIMEOUT > RESET_CYCLES) ? MEM_TIMEOUT : RESET_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_e           state_q, state_d;
    status_e          status_q, status_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halt_q, halt_d;
    logic             ready_en_q;
    opcode_e          op;
    logic             access_ok;
    logic             accepting;

    assign op        = opcode_e'(opcode);
    assign access_ok = halt_q && !core_busy;

    // ready_en_q keeps cmd_ready low until the first clock edge after reset release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            status_q   <= STAT_OK;
            cnt_q      <= '0;
            halt_q     <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            status_q   <= status_d;
            cnt_q      <= cnt_d;
            halt_q     <= halt_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        cnt_d    = cnt_q;
        halt_d   = halt_q;
        unique case (state_q)
            S_IDLE:     if (cmd_valid && ready_en_q) state_d = S_GET_DATA;
            S_GET_DATA: if (cmd_valid && ready_en_q) state_d = S_GET_ADDR;
            S_GET_ADDR: if (cmd_valid && ready_en_q) state_d = S_EXEC;
            S_EXEC: begin
                cnt_d    = '0;
                state_d  = S_RESP;
                status_d = STAT_OK;
                case (op)
                    OP_NOP:    ;
                    OP_RESUME: halt_d = 1'b0;
                    OP_HALT: begin
                        halt_d  = 1'b1;
                        state_d = S_WAIT_HALT;
                    end
                    OP_RESET:  state_d = S_RESET_PULSE;
                    OP_READ_REG, OP_WRITE_REG: begin
                        if (!access_ok) status_d = STAT_NOT_HALTED;
                    end
                    OP_READ_MEM, OP_WRITE_MEM: begin
                        if (!access_ok) status_d = STAT_NOT_HALTED;
                        else            state_d  = S_MEM_WAIT;
                    end
                    default:   status_d = STAT_ILLEGAL;
                endcase
            end
            S_WAIT_HALT: if (!core_busy) state_d = S_RESP;
            S_RESET_PULSE: begin
                if (cnt_q == CNT_W'(RESET_CYCLES - 1)) begin
                    state_d = S_RESP;
                    halt_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = S_RESP;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d  = S_RESP;
                    status_d = STAT_TIMEOUT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP:  if (resp_ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign accepting = (state_q == S_IDLE) || (state_q == S_GET_DATA) || (state_q == S_GET_ADDR);

    always_comb begin
        cmd_ready  = ready_en_q && accepting;
        cap_cmd    = cmd_ready && cmd_valid && (state_q == S_IDLE);
        cap_data   = cmd_ready && cmd_valid && (state_q == S_GET_DATA);
        cap_addr   = cmd_ready && cmd_valid && (state_q == S_GET_ADDR);
        resp_valid = (state_q == S_RESP);
        core_reset = (state_q == S_RESET_PULSE);
        mem_req    = (state_q == S_MEM_WAIT);
        mem_we     = mem_req && (op == OP_WRITE_MEM);
        reg_we     = (state_q == S_EXEC) && (op == OP_WRITE_REG) && access_ok;
        result_sel = RES_HOLD;
        if (state_q == S_EXEC)
            result_sel = ((op == OP_READ_REG) && access_ok) ? RES_REG : RES_ZERO;
        else if (mem_req && mem_ready && (op == OP_READ_MEM))
            result_sel = RES_MEM;
    end

    assign resp_status = status_q;
    assign core_halt   = halt_q;

endmodule

// File: rtl/core_debug_responder.sv
// Core debug responder: takes three-word commands off the shared debugger bus, drives the
// core register/memory debug ports and returns one result word on the same bus.
module core_debug_responder
    import core_debug_responder_pkg::*;
#(
    parameter int unsigned SIZE         = 32,
    parameter int unsigned RESET_CYCLES = 4,
    parameter int unsigned MEM_TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst,
    inout  wire  [SIZE-1:0] debugger_port,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    output logic            resp_valid,
    input  logic            resp_ack,
    output logic [1:0]      resp_status,
    output logic            core_halt,
    output logic            core_reset,
    input  logic            core_busy,
    output logic [4:0]      reg_addr,
    output logic [SIZE-1:0] reg_wdata,
    output logic            reg_we,
    input  logic [SIZE-1:0] reg_rdata,
    output logic [SIZE-1:0] mem_addr,
    output logic [SIZE-1:0] mem_wdata,
    output logic            mem_req,
    output logic            mem_we,
    input  logic [SIZE-1:0] mem_rdata,
    input  logic            mem_ready
);

    logic [3:0]      cmd_q;
    logic [SIZE-1:0] data_q, addr_q, result_q;
    logic            cap_cmd, cap_data, cap_addr;
    result_sel_e     result_sel;

    core_debug_responder_ctrl #(
        .RESET_CYCLES (RESET_CYCLES),
        .MEM_TIMEOUT  (MEM_TIMEOUT)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .resp_ack    (resp_ack),
        .opcode      (cmd_q),
        .core_busy   (core_busy),
        .mem_ready   (mem_ready),
        .cmd_ready   (cmd_ready),
        .cap_cmd     (cap_cmd),
        .cap_data    (cap_data),
        .cap_addr    (cap_addr),
        .result_sel  (result_sel),
        .resp_valid  (resp_valid),
        .resp_status (resp_status),
        .core_halt   (core_halt),
        .core_reset  (core_reset),
        .reg_we      (reg_we),
        .mem_req     (mem_req),
        .mem_we      (mem_we)
    );

    // Only the opcode nibble of the command word is meaningful, so only it is stored
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q    <= '0;
            data_q   <= '0;
            addr_q   <= '0;
            result_q <= '0;
        end else begin
            if (cap_cmd)  cmd_q  <= debugger_port[3:0];
            if (cap_data) data_q <= debugger_port;
            if (cap_addr) addr_q <= debugger_port;
            case (result_sel)
                RES_ZERO: result_q <= '0;
                RES_REG:  result_q <= reg_rdata;
                RES_MEM:  result_q <= mem_rdata;
                default:  ;
            endcase
        end
    end

    assign reg_addr      = addr_q[4:0];
    assign reg_wdata     = data_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = data_q;
    assign debugger_port = resp_valid ? result_q : 'z;

endmodule
